decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter ENABLE_M, default 0: 1 enables decode of RV32M (OP with funct7=0000001).
REQ-003 Parameter PC_W, default 32: width of the carried program counter.
REQ-004 Parameter DEPTH, default 2, legal 1..4: entries in the output buffer.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered and incoming entries
- in_valid  in  1  ins/in_pc valid
- in_ready  out  1  stage can accept
- ins  in  32  instruction word
- in_pc  in  PC_W  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_pc  out  PC_W  address of head instruction
- rs_addr1, rs_addr2, rd_addr  out  5 each  register numbers
- imm  out  32  sign-extended immediate
- alucode  out  6  ALU operation (existing ALU_* encodings plus ALU_MUL..ALU_REMU)
- aluop1_type, aluop2_type  out  2 each  OP_TYPE_* operand source
- wren, is_load, is_store, is_halt, is_illegal  out  1 each  control flags

Function
REQ-006 Decode SHALL be combinational on ins; the result SHALL enter the buffer on the accept edge (in_valid && in_ready), so the earliest out_valid is 1 cycle after accept.
REQ-007 The buffer SHALL be a FIFO of DEPTH entries with count 0..DEPTH; in_ready = (count < DEPTH), computed from registered count only.
REQ-008 Pop occurs when out_valid && out_ready; a simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-009 out_valid = (count != 0); all decoded outputs SHALL reflect the head entry and SHALL stay stable while out_valid && !out_ready.
REQ-010 Read/write pointers SHALL wrap modulo DEPTH.
REQ-011 flush SHALL set count to 0 on the next edge, drop any same-cycle input, and override push and pop.
REQ-012 Immediates:
- I-type (OPIMM, JALR, LOAD): sext(ins[31:20])
- shifts: zero-extended ins[24:20]
- S: sext({ins[31:25],ins[11:7]})
- B: sext({ins[31],ins[7],ins[30:25],ins[11:8],0})
- U (LUI, AUIPC): {ins[31:12],12'b0}
- J: sext({ins[31],ins[19:12],ins[20],ins[30:21],0})
- OP/other: 0
REQ-013 Unused rs fields SHALL be 0; rd_addr SHALL be 0 for BRANCH and STORE.
REQ-014 wren SHALL be 1 only for OPIMM, OP, LUI, AUIPC, JAL, JALR and LOAD with rd != 0.
REQ-015 Illegal conditions SHALL be:
- unknown opcode
- unlisted funct3 for BRANCH, LOAD, STORE
- bad funct7 for OP and shift-imm
- funct7=0000001 with ENABLE_M=0
REQ-016 An illegal entry SHALL still propagate, with is_illegal=1, wren=is_load=is_store=0 and alucode=0.
REQ-017 ECALL (0x00000073) SHALL set is_halt=1 and wren=0; FENCE SHALL decode as a legal no-op (all flags 0).
REQ-018 With ENABLE_M=1, funct3 000..111 SHALL map to ALU_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.

Reset
REQ-019 On rst: count and pointers are 0, out_valid=0, and in_ready=1 the following cycle; buffer contents need not clear but SHALL be masked by out_valid=0.
REQ-020 rst SHALL take priority over flush and over any handshake in the same cycle; reset mid-stream SHALL discard all entries.

Verification
REQ-021 ins=0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle: rd=1, rs1=2, imm=0xFFFFFFFF, alucode=ALU_ADD, wren=1.
REQ-022 DEPTH=2, out_ready=0, 3 back-to-back valid inputs -> in_ready=0 after the 2nd accept; 3rd held; out_ready=1 then yields all 3 in order with no loss or duplication.
REQ-023 ins=0xFFDFF06F (jal x0,-4) -> imm=0xFFFFFFFC, alucode=ALU_JAL, wren=0.
REQ-024 ins=0x022081B3 (mul x3,x1,x2) -> is_illegal=1 with ENABLE_M=0; alucode=ALU_MUL, wren=1 with ENABLE_M=1.
REQ-025 Buffer full with flush and in_valid asserted together -> next cycle out_valid=0 and count=0; the flushed-cycle input never appears.
REQ-026 Assert rst while 2 entries are held -> next cycle out_valid=0 and in_ready=1; the first post-reset instruction emerges after 1 cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I(+M) instruction decoder feeding a small FIFO of decoded entries.
// Decode is combinational on ins; results are captured on the accept edge and presented from the head entry.
module decode_stage #(
  parameter bit ENABLE_M = 1'b0,
  parameter int PC_W     = 32,
  parameter int DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ins,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs_addr1,
  output logic [4:0]      rs_addr2,
  output logic [4:0]      rd_addr,
  output logic [31:0]     imm,
  output logic [5:0]      alucode,
  output logic [1:0]      aluop1_type,
  output logic [1:0]      aluop2_type,
  output logic            wren,
  output logic            is_load,
  output logic            is_store,
  output logic            is_halt,
  output logic            is_illegal
);

  localparam logic [5:0] ALU_ILL    = 6'd0;
  localparam logic [5:0] ALU_LUI    = 6'd1;
  localparam logic [5:0] ALU_AUIPC  = 6'd2;
  localparam logic [5:0] ALU_JAL    = 6'd3;
  localparam logic [5:0] ALU_JALR   = 6'd4;
  localparam logic [5:0] ALU_BEQ    = 6'd5;
  localparam logic [5:0] ALU_BNE    = 6'd6;
  localparam logic [5:0] ALU_BLT    = 6'd7;
  localparam logic [5:0] ALU_BGE    = 6'd8;
  localparam logic [5:0] ALU_BLTU   = 6'd9;
  localparam logic [5:0] ALU_BGEU   = 6'd10;
  localparam logic [5:0] ALU_LB     = 6'd11;
  localparam logic [5:0] ALU_LH     = 6'd12;
  localparam logic [5:0] ALU_LW     = 6'd13;
  localparam logic [5:0] ALU_LBU    = 6'd14;
  localparam logic [5:0] ALU_LHU    = 6'd15;
  localparam logic [5:0] ALU_SB     = 6'd16;
  localparam logic [5:0] ALU_SH     = 6'd17;
  localparam logic [5:0] ALU_SW     = 6'd18;
  localparam logic [5:0] ALU_ADD    = 6'd19;
  localparam logic [5:0] ALU_SUB    = 6'd20;
  localparam logic [5:0] ALU_SLT    = 6'd21;
  localparam logic [5:0] ALU_SLTU   = 6'd22;
  localparam logic [5:0] ALU_XOR    = 6'd23;
  localparam logic [5:0] ALU_OR     = 6'd24;
  localparam logic [5:0] ALU_AND    = 6'd25;
  localparam logic [5:0] ALU_SLL    = 6'd26;
  localparam logic [5:0] ALU_SRL    = 6'd27;
  localparam logic [5:0] ALU_SRA    = 6'd28;
  localparam logic [5:0] ALU_MUL    = 6'd29;
  localparam logic [5:0] ALU_MULH   = 6'd30;
  localparam logic [5:0] ALU_MULHSU = 6'd31;
  localparam logic [5:0] ALU_MULHU  = 6'd32;
  localparam logic [5:0] ALU_DIV    = 6'd33;
  localparam logic [5:0] ALU_DIVU   = 6'd34;
  localparam logic [5:0] ALU_REM    = 6'd35;
  localparam logic [5:0] ALU_REMU   = 6'd36;
  localparam logic [5:0] ALU_NOP    = 6'd37;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [1:0] OP_TYPE_REG  = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
  localparam logic [1:0] OP_TYPE_PC   = 2'd3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << PTR_W;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [5:0]      alucode;
    logic [1:0]      op1;
    logic [1:0]      op2;
    logic            wren;
    logic            is_load;
    logic            is_store;
    logic            is_halt;
    logic            is_illegal;
  } entry_t;

  // Pointers walk 0..DEPTH-1 so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s, imm_sh_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s;
  logic        illegal_s;
  entry_t      dec_s;
  entry_t      head_s;
  entry_t      mem_r [SLOTS];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [2:0]  count_r;
  logic        push_s, pop_s;

  assign opcode_s = ins[6:0];
  assign funct3_s = ins[14:12];
  assign funct7_s = ins[31:25];
  assign imm_i_s  = {{20{ins[31]}}, ins[31:20]};
  assign imm_sh_s = {27'd0, ins[24:20]};
  assign imm_st_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b_s  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u_s  = {ins[31:12], 12'd0};
  assign imm_j_s  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Combinational decode of the incoming instruction word.
  always_comb begin
    dec_s     = '0;
    dec_s.pc  = in_pc;
    illegal_s = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        dec_s.rd = ins[11:7]; dec_s.imm = imm_u_s; dec_s.alucode = ALU_LUI;
        dec_s.op1 = OP_TYPE_NONE; dec_s.op2 = OP_TYPE_IMM; dec_s.wren = 1'b1;
      end
      OPC_AUIPC: begin
        dec_s.rd = ins[11:7]; dec_s.imm = imm_u_s; dec_s.alucode = ALU_AUIPC;
        dec_s.op1 = OP_TYPE_PC; dec_s.op2 = OP_TYPE_IMM; dec_s.wren = 1'b1;
      end
      OPC_JAL: begin
        dec_s.rd = ins[11:7]; dec_s.imm = imm_j_s; dec_s.alucode = ALU_JAL;
        dec_s.op1 = OP_TYPE_PC; dec_s.op2 = OP_TYPE_IMM; dec_s.wren = 1'b1;
      end
      OPC_JALR: begin
        dec_s.rs1 = ins[19:15]; dec_s.rd = ins[11:7]; dec_s.imm = imm_i_s;
        dec_s.alucode = ALU_JALR; dec_s.op1 = OP_TYPE_REG; dec_s.op2 = OP_TYPE_IMM;
        dec_s.wren = 1'b1;
      end
      OPC_BRANCH: begin
        dec_s.rs1 = ins[19:15]; dec_s.rs2 = ins[24:20]; dec_s.imm = imm_b_s;
        dec_s.op1 = OP_TYPE_REG; dec_s.op2 = OP_TYPE_REG;
        case (funct3_s)
          3'b000:  dec_s.alucode = ALU_BEQ;
          3'b001:  dec_s.alucode = ALU_BNE;
          3'b100:  dec_s.alucode = ALU_BLT;
          3'b101:  dec_s.alucode = ALU_BGE;
          3'b110:  dec_s.alucode = ALU_BLTU;
          3'b111:  dec_s.alucode = ALU_BGEU;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_s.rs1 = ins[19:15]; dec_s.rd = ins[11:7]; dec_s.imm = imm_i_s;
        dec_s.op1 = OP_TYPE_REG; dec_s.op2 = OP_TYPE_IMM;
        dec_s.wren = 1'b1; dec_s.is_load = 1'b1;
        case (funct3_s)
          3'b000:  dec_s.alucode = ALU_LB;
          3'b001:  dec_s.alucode = ALU_LH;
          3'b010:  dec_s.alucode = ALU_LW;
          3'b100:  dec_s.alucode = ALU_LBU;
          3'b101:  dec_s.alucode = ALU_LHU;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_s.rs1 = ins[19:15]; dec_s.rs2 = ins[24:20]; dec_s.imm = imm_st_s;
        dec_s.op1 = OP_TYPE_REG; dec_s.op2 = OP_TYPE_REG; dec_s.is_store = 1'b1;
        case (funct3_s)
          3'b000:  dec_s.alucode = ALU_SB;
          3'b001:  dec_s.alucode = ALU_SH;
          3'b010:  dec_s.alucode = ALU_SW;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec_s.rs1 = ins[19:15]; dec_s.rd = ins[11:7]; dec_s.imm = imm_i_s;
        dec_s.op1 = OP_TYPE_REG; dec_s.op2 = OP_TYPE_IMM; dec_s.wren = 1'b1;
        case (funct3_s)
          3'b000: dec_s.alucode = ALU_ADD;
          3'b010: dec_s.alucode = ALU_SLT;
          3'b011: dec_s.alucode = ALU_SLTU;
          3'b100: dec_s.alucode = ALU_XOR;
          3'b110: dec_s.alucode = ALU_OR;
          3'b111: dec_s.alucode = ALU_AND;
          3'b001: begin
            dec_s.imm = imm_sh_s; dec_s.alucode = ALU_SLL;
            illegal_s = (funct7_s != 7'b0000000);
          end
          3'b101: begin
            dec_s.imm     = imm_sh_s;
            dec_s.alucode = funct7_s[5] ? ALU_SRA : ALU_SRL;
            illegal_s     = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec_s.rs1 = ins[19:15]; dec_s.rs2 = ins[24:20]; dec_s.rd = ins[11:7];
        dec_s.op1 = OP_TYPE_REG; dec_s.op2 = OP_TYPE_REG; dec_s.wren = 1'b1;
        if (funct7_s == 7'b0000001) begin
          if (ENABLE_M) begin
            case (funct3_s)
              3'b000:  dec_s.alucode = ALU_MUL;
              3'b001:  dec_s.alucode = ALU_MULH;
              3'b010:  dec_s.alucode = ALU_MULHSU;
              3'b011:  dec_s.alucode = ALU_MULHU;
              3'b100:  dec_s.alucode = ALU_DIV;
              3'b101:  dec_s.alucode = ALU_DIVU;
              3'b110:  dec_s.alucode = ALU_REM;
              3'b111:  dec_s.alucode = ALU_REMU;
              default: illegal_s = 1'b1;
            endcase
          end else begin
            illegal_s = 1'b1;
          end
        end else if (funct7_s == 7'b0000000) begin
          case (funct3_s)
            3'b000:  dec_s.alucode = ALU_ADD;
            3'b001:  dec_s.alucode = ALU_SLL;
            3'b010:  dec_s.alucode = ALU_SLT;
            3'b011:  dec_s.alucode = ALU_SLTU;
            3'b100:  dec_s.alucode = ALU_XOR;
            3'b101:  dec_s.alucode = ALU_SRL;
            3'b110:  dec_s.alucode = ALU_OR;
            3'b111:  dec_s.alucode = ALU_AND;
            default: illegal_s = 1'b1;
          endcase
        end else if (funct7_s == 7'b0100000) begin
          case (funct3_s)
            3'b000:  dec_s.alucode = ALU_SUB;
            3'b101:  dec_s.alucode = ALU_SRA;
            default: illegal_s = 1'b1;
          endcase
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_FENCE: dec_s.alucode = ALU_NOP;
      OPC_SYSTEM: begin
        // Only ECALL is recognised; it halts and never writes back.
        dec_s.alucode = ALU_NOP;
        dec_s.is_halt = (ins == 32'h0000_0073);
        illegal_s     = (ins != 32'h0000_0073);
      end
      default: illegal_s = 1'b1;
    endcase
    dec_s.wren = dec_s.wren & (dec_s.rd != 5'd0);
    if (illegal_s) begin
      dec_s            = '0;
      dec_s.pc         = in_pc;
      dec_s.alucode    = ALU_ILL;
      dec_s.is_illegal = 1'b1;
    end else begin
      dec_s.is_illegal = 1'b0;
    end
  end

  assign in_ready  = (count_r < 3'(DEPTH));
  assign out_valid = (count_r != 3'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // FIFO occupancy and pointers; reset beats flush, flush beats any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= 3'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      count_r  <= 3'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are masked by out_valid so they need no reset.
  always_ff @(posedge clk) begin
    if (push_s && !flush && !rst) begin
      mem_r[wr_ptr_r] <= dec_s;
    end
  end

  assign head_s      = mem_r[rd_ptr_r];
  assign out_pc      = head_s.pc;
  assign rs_addr1    = head_s.rs1;
  assign rs_addr2    = head_s.rs2;
  assign rd_addr     = head_s.rd;
  assign imm         = head_s.imm;
  assign alucode     = head_s.alucode;
  assign aluop1_type = head_s.op1;
  assign aluop2_type = head_s.op2;
  assign wren        = head_s.wren;
  assign is_load     = head_s.is_load;
  assign is_store    = head_s.is_store;
  assign is_halt     = head_s.is_halt;
  assign is_illegal  = head_s.is_illegal;

endmodule
